// File: rtl/mac7177_acc35.sv
// mac7177_acc35 -- streaming multiply-accumulate front end for sntrup1013.
//
// Each cycle accepts one pair of centered mod-7177 coefficients and forms
// their product. It accumulates the products of one sequence into a 35-bit
// signed sum and emits that raw sum once per sequence. The sum feeds the
// 3-cycle mod-7177 centered reducer. red_valid is out_valid delayed to
// line up with the reducer output.
//
// Optional feature: define MAC7177_RANGE_CHECK_EN to build the sticky err
// flag. When enabled, err is set by any of the following:
//   - an out-of-range valid coefficient;
//   - the (P_MAX+1)th term of a sequence.
// Without the macro, err is tied to 0 and no check logic is built.
//
// Handshake: valid-only streaming. A term is consumed on every rising edge
// where in_valid is high, and there is no ready/backpressure. in_last is
// meaningful only together with in_valid. out_valid is a single-cycle
// pulse, and acc_out/term_cnt hold their value until the next pulse.
//
// Pipeline: stage 1 registers the product; stage 2 accumulates. A last
// term presented in the cycle ending at edge t+1 appears on out_valid
// after edge t+2.

module mac7177_acc35 #(
    parameter int P_MAX   = 1013,
    parameter int RED_LAT = 3
) (
    input  logic               clk,
    input  logic               Reset,
    input  logic               in_valid,
    input  logic               in_last,
    input  logic signed [12:0] a_in,
    input  logic signed [12:0] b_in,
    output logic signed [34:0] acc_out,
    output logic               out_valid,
    output logic [9:0]         term_cnt,
    output logic               red_valid,
    output logic               err
);

    // The term counter is 10 bits wide, so sequences beyond 1023 terms
    // cannot be counted. Reject such parameterisations at elaboration.
    if (P_MAX > 1023) begin : g_p_max_check
        $error("mac7177_acc35: P_MAX must not exceed 1023");
    end

    // ------------------------------------------------------------------
    // Stage 1: product register and qualified flags
    // ------------------------------------------------------------------
    logic signed [25:0] prod_d, prod_q;
    logic               v1_d, v1_q;
    logic               l1_d, l1_q;

    // 13x13 signed multiply. Both operands are sign-extended to the full
    // 26-bit product width first.
    assign prod_d = 26'(a_in) * 26'(b_in);
    assign v1_d   = in_valid;
    assign l1_d   = in_valid & in_last;   // a stray in_last is dropped here

    // Stage-1 registers. They clear on reset so that any in-flight term is
    // discarded.
    always_ff @(posedge clk) begin
        if (Reset) begin
            prod_q <= '0;
            v1_q   <= 1'b0;
            l1_q   <= 1'b0;
        end else begin
            prod_q <= prod_d;
            v1_q   <= v1_d;
            l1_q   <= l1_d;
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: accumulate, count, emit
    // ------------------------------------------------------------------
    logic signed [34:0] acc_d, acc_q;
    logic [9:0]         cnt_d, cnt_q;
    logic               first_d, first_q;
    logic signed [34:0] acc_out_d, acc_out_q;
    logic [9:0]         term_cnt_d, term_cnt_q;
    logic               out_valid_d, out_valid_q;

    logic signed [34:0] base_sum;
    logic signed [34:0] sum;
    logic [9:0]         cnt_new;

    // Starting a sequence uses zero as the base instead of clearing acc.
    // This lets a first term that arrives right after a last term begin
    // cleanly, without a dead cycle.
    assign base_sum = first_q ? 35'sd0 : acc_q;
    assign sum      = base_sum + 35'(prod_q);
    assign cnt_new  = first_q ? 10'd1 : cnt_q + 10'd1;

    // Next-state logic for the accumulator, the counter and the output
    // registers. Bubbles (v1_q low) leave every value unchanged.
    always_comb begin
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        first_d     = first_q;
        acc_out_d   = acc_out_q;
        term_cnt_d  = term_cnt_q;
        out_valid_d = 1'b0;
        if (v1_q) begin
            acc_d   = sum;
            cnt_d   = cnt_new;
            first_d = 1'b0;
            if (l1_q) begin
                acc_out_d   = sum;
                term_cnt_d  = cnt_new;
                out_valid_d = 1'b1;
                first_d     = 1'b1;
            end
        end
    end

    // Stage-2 registers. A reset drops the partial sum and re-arms first.
    always_ff @(posedge clk) begin
        if (Reset) begin
            acc_q       <= '0;
            cnt_q       <= '0;
            first_q     <= 1'b1;
            acc_out_q   <= '0;
            term_cnt_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            first_q     <= first_d;
            acc_out_q   <= acc_out_d;
            term_cnt_q  <= term_cnt_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign acc_out   = acc_out_q;
    assign term_cnt  = term_cnt_q;
    assign out_valid = out_valid_q;

    // ------------------------------------------------------------------
    // Reducer-aligned valid: RED_LAT-deep delay line of out_valid
    // ------------------------------------------------------------------
    logic [RED_LAT-1:0] red_sr_d, red_sr_q;

    // Shift out_valid into the delay line one position per cycle.
    always_comb begin
        red_sr_d    = red_sr_q;
        red_sr_d[0] = out_valid_q;
        for (int i = 1; i < RED_LAT; i++) begin
            red_sr_d[i] = red_sr_q[i-1];
        end
    end

    // Delay-line register. A reset also cancels pulses still in flight.
    always_ff @(posedge clk) begin
        if (Reset) begin
            red_sr_q <= '0;
        end else begin
            red_sr_q <= red_sr_d;
        end
    end

    assign red_valid = red_sr_q[RED_LAT-1];

    // ------------------------------------------------------------------
    // Optional range / length checking
    // ------------------------------------------------------------------
`ifdef MAC7177_RANGE_CHECK_EN
    localparam logic signed [12:0] COEF_MAX = 13'sd3588;
    localparam logic signed [12:0] COEF_MIN = -13'sd3588;
    localparam logic [10:0]        LEN_BAD  = 11'(P_MAX + 1);

    logic range_bad_d, range_bad_q;
    logic len_bad;
    logic err_d, err_q;

    assign range_bad_d = in_valid &
                         ((a_in > COEF_MAX) || (a_in < COEF_MIN) ||
                          (b_in > COEF_MAX) || (b_in < COEF_MIN));

    // The (P_MAX+1)th term is the first one outside the proven 35-bit bound.
    assign len_bad = v1_q && ({1'b0, cnt_new} == LEN_BAD);
    assign err_d   = err_q | range_bad_q | len_bad;

    // Check registers. err stays set until Reset.
    always_ff @(posedge clk) begin
        if (Reset) begin
            range_bad_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            range_bad_q <= range_bad_d;
            err_q       <= err_d;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule
